hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one parameter: FLUSH_CYCLES, default 2, number of bubble cycles issued after a branch mispredict flush (legal range 1..15).
REQ-002 The block SHALL have these ports (name  direction  width  meaning), one per line:
- CLK  in  1  sole clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- inst_vld  in  1  an instruction is present in decode.
- rs1_p  in  5  rs1 index of the instruction in decode.
- rs2_p  in  5  rs2 index of the instruction in decode.
- rs1_ren_p  in  1  instruction in decode reads rs1.
- rs2_ren_p  in  1  instruction in decode reads rs2.
- ex_vld  in  1  the EX-stage instruction is valid.
- ex_rd  in  5  EX-stage destination register.
- ex_rd_wen  in  1  EX-stage instruction writes rd.
- ex_is_load  in  1  EX-stage instruction is a load.
- alu_flush  in  1  branch mispredict flush from the ALU.
- lsu_ready  in  1  LSU can accept work.
- stall_cnt_clr  in  1  synchronous clear of stall_cnt.
- nop_insert  out  1  decode outputs a bubble this cycle.
- if_hold  out  1  fetch and decode hold their current instruction.
- flush_busy  out  1  flush drain in progress.
- state  out  2  current FSM state (RUN=0, FLUSH=1, LSU_WAIT=2).
- stall_cnt  out  16  saturating count of stall/bubble cycles.

Function
REQ-003 The block SHALL define hazard = inst_vld & ex_vld & ex_is_load & ex_rd_wen & (ex_rd != 0) & ((rs1_ren_p & rs1_p == ex_rd) | (rs2_ren_p & rs2_p == ex_rd)).
REQ-004 The block SHALL implement a 3-state FSM (RUN, FLUSH, LSU_WAIT); state 3 is unreachable and, if reached, SHALL go to RUN on the next edge.
REQ-005 In every state, input priority SHALL be alu_flush, then ~lsu_ready, then hazard.
REQ-006 RUN, alu_flush=1: outputs SHALL be nop_insert=1 and flush_busy=1 in the same cycle; next state FLUSH; down-counter loaded with FLUSH_CYCLES-1.
REQ-007 RUN, ~lsu_ready and no flush: output SHALL be if_hold=1 in the same cycle; next state LSU_WAIT.
REQ-008 RUN, hazard only: outputs SHALL be nop_insert=1 and if_hold=1 for that cycle only; state stays RUN, so the bubble lasts exactly one cycle per load-use pair.
REQ-009 RUN, no condition active: nop_insert, if_hold and flush_busy SHALL all be 0.
REQ-010 FLUSH: outputs SHALL be nop_insert=1, flush_busy=1 and if_hold=0; the counter decrements each cycle, with state becoming RUN on the edge where the counter is 0.
REQ-011 Total bubbles per isolated flush SHALL be exactly FLUSH_CYCLES.
REQ-012 FLUSH, alu_flush=1 again: the counter SHALL reload to FLUSH_CYCLES-1 and state stays FLUSH.
REQ-013 FLUSH: lsu_ready and hazard SHALL be ignored.
REQ-014 LSU_WAIT: output SHALL be if_hold=1; next state is RUN on the first cycle lsu_ready=1, and that cycle has if_hold=0.
REQ-015 LSU_WAIT, alu_flush=1: the block SHALL behave as REQ-006 (go to FLUSH).
REQ-016 FLUSH_CYCLES=1: FLUSH SHALL last one cycle, giving one bubble in the alu_flush cycle plus one in FLUSH, i.e. total 2. REQ-011 therefore applies only for FLUSH_CYCLES>=2.
REQ-017 stall_cnt SHALL increment by 1 on each edge where nop_insert|if_hold=1, saturate at 16'hFFFF, and not wrap.
REQ-018 stall_cnt_clr SHALL load stall_cnt with 0 on the next edge and take priority over increment.
REQ-019 state SHALL equal the registered FSM state. All other outputs SHALL be combinational from state, counter and inputs, with no input-to-output path except through the decode of REQ-003 to REQ-015.

Reset
REQ-020 While RST=1, state SHALL be RUN, the counter 0 and stall_cnt 0; nop_insert, if_hold and flush_busy SHALL be forced to 0 regardless of inputs.
REQ-021 Assertion of RST mid-FLUSH or mid-LSU_WAIT SHALL abort immediately and asynchronously; there is no residual bubble after release.
REQ-022 The first edge after RST deasserts SHALL evaluate inputs as in RUN.

Verification
REQ-023 Load-use: ex_is_load=1, ex_rd=5, ex_rd_wen=1, rs2_p=5, rs2_ren_p=1, all valids=1 for one cycle -> nop_insert=if_hold=1 for that cycle, state=RUN, stall_cnt=1.
REQ-024 x0 and no-read cases: same as REQ-023 but ex_rd=0, or rs2_ren_p=0 -> nop_insert=0, if_hold=0.
REQ-025 Flush: FLUSH_CYCLES=2, alu_flush pulse at cycle N -> nop_insert=1 at N and N+1, flush_busy=1 at N and N+1, state=RUN at N+2. Second alu_flush at N+1 -> bubbles at N..N+2.
REQ-026 LSU stall: lsu_ready=0 for 3 cycles while hazard=1 -> if_hold=1 and nop_insert=0 for 3 cycles, state=LSU_WAIT for 2 of them. alu_flush during LSU_WAIT -> state=FLUSH next edge.
REQ-027 Saturation and clear: hold lsu_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and stays there. Pulse stall_cnt_clr together with if_hold=1 -> stall_cnt=0.
REQ-028 Reset mid-flush: RST asserted in FLUSH with counter=1 -> outputs go to 0 without waiting for CLK, state=RUN. After release with idle inputs -> nop_insert=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch-flush drain and LSU back-pressure hold.
// Exposes FSM state and a saturating stall/bubble counter for observability.
module hazard_ctrl #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        inst_vld,
   input  logic [4:0]  rs1_p,
   input  logic [4:0]  rs2_p,
   input  logic        rs1_ren_p,
   input  logic        rs2_ren_p,
   input  logic        ex_vld,
   input  logic [4:0]  ex_rd,
   input  logic        ex_rd_wen,
   input  logic        ex_is_load,
   input  logic        alu_flush,
   input  logic        lsu_ready,
   input  logic        stall_cnt_clr,
   output logic        nop_insert,
   output logic        if_hold,
   output logic        flush_busy,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      FLUSH    = 2'd1,
      LSU_WAIT = 2'd2
   } state_t;

   localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic        hazard;
   logic        rs1_hit;
   logic        rs2_hit;

   assign rs1_hit = rs1_ren_p && (rs1_p == ex_rd);
   assign rs2_hit = rs2_ren_p && (rs2_p == ex_rd);
   assign hazard  = inst_vld && ex_vld && ex_is_load && ex_rd_wen &&
                    (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

   assign state = state_q;

   // lsu_ready is a level: low means the LSU refuses work and fetch/decode must hold.
   // Priority everywhere is alu_flush, then ~lsu_ready, then hazard; RST gates all outputs.
   always_comb begin
      nop_insert = 1'b0;
      if_hold    = 1'b0;
      flush_busy = 1'b0;
      if (!RST) begin
         case (state_q)
            RUN, LSU_WAIT: begin
               if (alu_flush) begin
                  nop_insert = 1'b1;
                  flush_busy = 1'b1;
               end else if (!lsu_ready) begin
                  if_hold = 1'b1;
               end else if (state_q == RUN && hazard) begin
                  nop_insert = 1'b1;
                  if_hold    = 1'b1;
               end
            end
            FLUSH: begin
               nop_insert = 1'b1;
               flush_busy = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Leaving FLUSH when the counter is at or below 1 makes the alu_flush cycle
   // plus the FLUSH cycles total exactly FLUSH_CYCLES bubbles (2 when FLUSH_CYCLES=1).
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= RUN;
         cnt_q   <= 4'd0;
      end else begin
         case (state_q)
            RUN, LSU_WAIT: begin
               if (alu_flush) begin
                  state_q <= FLUSH;
                  cnt_q   <= RELOAD;
               end else if (!lsu_ready) begin
                  state_q <= LSU_WAIT;
               end else begin
                  state_q <= RUN;
               end
            end
            FLUSH: begin
               if (alu_flush) begin
                  cnt_q <= RELOAD;
               end else if (cnt_q <= 4'd1) begin
                  state_q <= RUN;
                  cnt_q   <= 4'd0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= RUN;
               cnt_q   <= 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_cnt <= 16'd0;
      end else if (stall_cnt_clr) begin
         stall_cnt <= 16'd0;
      end else if ((nop_insert || if_hold) && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, flush drain, LSU hold, counter saturation/clear, async reset.
module tb_hazard_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        inst_vld, ex_vld, ex_rd_wen, ex_is_load;
   logic [4:0]  rs1_p, rs2_p, ex_rd;
   logic        rs1_ren_p, rs2_ren_p;
   logic        alu_flush, lsu_ready, stall_cnt_clr;
   logic        nop_insert, if_hold, flush_busy;
   logic [1:0]  state;
   logic [15:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
      .CLK(CLK), .RST(RST),
      .inst_vld(inst_vld), .rs1_p(rs1_p), .rs2_p(rs2_p),
      .rs1_ren_p(rs1_ren_p), .rs2_ren_p(rs2_ren_p),
      .ex_vld(ex_vld), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load),
      .alu_flush(alu_flush), .lsu_ready(lsu_ready), .stall_cnt_clr(stall_cnt_clr),
      .nop_insert(nop_insert), .if_hold(if_hold), .flush_busy(flush_busy),
      .state(state), .stall_cnt(stall_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      inst_vld = 1'b1; ex_vld = 1'b1; ex_rd_wen = 1'b0; ex_is_load = 1'b0;
      rs1_p = 5'd0; rs2_p = 5'd0; ex_rd = 5'd0;
      rs1_ren_p = 1'b0; rs2_ren_p = 1'b0;
      alu_flush = 1'b0; lsu_ready = 1'b1; stall_cnt_clr = 1'b0;
   endtask

   task automatic load_use();
      ex_is_load = 1'b1; ex_rd = 5'd5; ex_rd_wen = 1'b1;
      rs2_p = 5'd5; rs2_ren_p = 1'b1;
   endtask

   task automatic outs(input string tag, input logic n, input logic h, input logic f);
      check({tag, "_nop"}, 32'(nop_insert), 32'(n));
      check({tag, "_hold"}, 32'(if_hold), 32'(h));
      check({tag, "_fb"}, 32'(flush_busy), 32'(f));
   endtask

   initial begin
      idle();
      RST = 1'b1;
      alu_flush = 1'b1;
      lsu_ready = 1'b0;
      #12;
      outs("rst_forced", 0, 0, 0);
      check("rst_state", 32'(state), 0);
      check("rst_cnt", 32'(stall_cnt), 0);
      idle();
      tick();
      RST = 1'b0;
      #1;
      outs("post_rst", 0, 0, 0);

      // load-use bubble
      load_use(); #1;
      outs("lu", 1, 1, 0);
      tick(); idle(); #1;
      check("lu_state", 32'(state), 0);
      check("lu_cnt", 32'(stall_cnt), 1);

      // non-hazard variants, cleared before the edge
      load_use(); ex_rd = 5'd0; rs2_p = 5'd0; #1;
      outs("x0", 0, 0, 0);
      load_use(); rs2_ren_p = 1'b0; #1;
      outs("noread", 0, 0, 0);
      load_use(); ex_vld = 1'b0; #1;
      outs("exinv", 0, 0, 0);
      idle(); load_use(); rs2_ren_p = 1'b0; rs1_p = 5'd5; rs1_ren_p = 1'b1; #1;
      outs("rs1hit", 1, 1, 0);
      idle(); #1;
      tick();
      check("nocount", 32'(stall_cnt), 1);

      // isolated flush: bubbles at N, N+1
      alu_flush = 1'b1; #1;
      outs("fl_n", 1, 0, 1);
      tick(); alu_flush = 1'b0; #1;
      check("fl_n1_state", 32'(state), 1);
      outs("fl_n1", 1, 0, 1);
      tick();
      check("fl_n2_state", 32'(state), 0);
      outs("fl_n2", 0, 0, 0);
      check("fl_cnt", 32'(stall_cnt), 3);

      // back-to-back flush: bubbles N..N+2
      alu_flush = 1'b1;
      tick();
      check("dfl_n1_state", 32'(state), 1);
      tick(); alu_flush = 1'b0; #1;
      check("dfl_n2_state", 32'(state), 1);
      outs("dfl_n2", 1, 0, 1);
      tick();
      check("dfl_n3_state", 32'(state), 0);
      check("dfl_cnt", 32'(stall_cnt), 6);

      // LSU stall with a hazard present: hold without bubble for 3 cycles
      load_use(); lsu_ready = 1'b0; #1;
      outs("lsu1", 0, 1, 0);
      tick();
      check("lsu2_state", 32'(state), 2);
      outs("lsu2", 0, 1, 0);
      tick();
      check("lsu3_state", 32'(state), 2);
      outs("lsu3", 0, 1, 0);
      tick(); idle(); #1;
      check("lsu4_state", 32'(state), 2);
      outs("lsu4", 0, 0, 0);
      tick();
      check("lsu_exit_state", 32'(state), 0);
      check("lsu_cnt", 32'(stall_cnt), 9);

      // flush during LSU_WAIT
      lsu_ready = 1'b0;
      tick();
      check("lw_state", 32'(state), 2);
      alu_flush = 1'b1; #1;
      outs("lw_flush", 1, 0, 1);
      tick(); alu_flush = 1'b0; lsu_ready = 1'b1; #1;
      check("lw_fl_state", 32'(state), 1);
      tick();
      check("lw_done_state", 32'(state), 0);
      check("lw_cnt", 32'(stall_cnt), 12);

      // FLUSH ignores lsu_ready and hazard
      alu_flush = 1'b1;
      tick(); alu_flush = 1'b0; lsu_ready = 1'b0; load_use(); #1;
      check("fign_state", 32'(state), 1);
      outs("fign", 1, 0, 1);
      tick();
      check("fign_exit_state", 32'(state), 0);
      check("fign_hold", 32'(if_hold), 1);
      idle(); #1;
      tick();
      check("fign_state2", 32'(state), 0);
      check("fign_cnt", 32'(stall_cnt), 14);

      // clear wins over increment
      lsu_ready = 1'b0; stall_cnt_clr = 1'b1;
      tick(); stall_cnt_clr = 1'b0;
      check("clr_cnt", 32'(stall_cnt), 0);
      tick();
      check("clr_inc", 32'(stall_cnt), 1);
      lsu_ready = 1'b1;
      tick();
      check("clr_state", 32'(state), 0);

      // saturation
      lsu_ready = 1'b0;
      repeat (70000) tick();
      check("sat_cnt", 32'(stall_cnt), 32'hFFFF);
      check("sat_state", 32'(state), 2);
      tick();
      check("sat_hold", 32'(stall_cnt), 32'hFFFF);
      stall_cnt_clr = 1'b1;
      tick(); stall_cnt_clr = 1'b0;
      check("sat_clr", 32'(stall_cnt), 0);
      lsu_ready = 1'b1;
      tick();

      // asynchronous reset in FLUSH with counter=1
      alu_flush = 1'b1;
      tick(); alu_flush = 1'b0; #1;
      check("rf_state", 32'(state), 1);
      outs("rf_pre", 1, 0, 1);
      #1 RST = 1'b1;
      #1;
      outs("rf_async", 0, 0, 0);
      check("rf_async_state", 32'(state), 0);
      tick();
      RST = 1'b0;
      tick(); #1;
      outs("rf_after", 0, 0, 0);
      check("rf_after_state", 32'(state), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
